// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoder select among 8 requesters,
// with a dead-time gap between grants. Optional forced revoke: ARB_TIMEOUT_EN.
module rr_decoder_arbiter #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned MAX_HOLD   = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic       sel_vld,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned GW = 4;
  localparam int unsigned HW = 8;

  if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("GAP_CYCLES must be in 1..15");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [GW-1:0] gap_cnt;
  logic [IW-1:0] winner_c;
  logic [IW-1:0] idx_c;
  logic          any_req_c;
  logic          arb_c;

  // Scan farthest-first so the channel nearest after last overrides.
  always_comb begin
    winner_c  = '0;
    idx_c     = '0;
    any_req_c = |req;
    for (int i = N; i >= 1; i--) begin
      idx_c = last + IW'(i);
      if (req[idx_c]) winner_c = idx_c;
    end
  end

  assign arb_c = (state == IDLE) ||
                 ((state == GAP) && (gap_cnt == GW'(GAP_CYCLES - 1)));

`ifdef ARB_TIMEOUT_EN
  logic [HW-1:0] hold_cnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= IW'(N - 1);
      gap_cnt <= '0;
      sel     <= '0;
      sel_vld <= 1'b0;
      gnt     <= '0;
      busy    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      if (arb_c) begin
        if (any_req_c) begin
          state   <= GRANT;
          sel     <= winner_c;
          sel_vld <= 1'b1;
          gnt     <= N'(1) << winner_c;
          busy    <= 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_cnt <= '0;
`endif
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          GRANT: begin
            if (!req[sel]) begin
              state   <= GAP;
              gap_cnt <= '0;
              sel_vld <= 1'b0;
              gnt     <= '0;
              last    <= sel;
            end
`ifdef ARB_TIMEOUT_EN
            else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
              state   <= GAP;
              gap_cnt <= '0;
              sel_vld <= 1'b0;
              gnt     <= '0;
              last    <= sel;
              timeout <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
`endif
          end
          GAP:     gap_cnt <= gap_cnt + GW'(1);
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Randomized and directed bench for rr_decoder_arbiter against a cycle-level
// reference model of the arbitration rules. Honours ARB_TIMEOUT_EN.
module tb_rr_decoder_arbiter;

  localparam int unsigned GAP  = 2;
  localparam int unsigned HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [2:0] sel;
  logic       sel_vld;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  always #5 clk = ~clk;

  rr_decoder_arbiter #(.GAP_CYCLES(GAP), .MAX_HOLD(HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .sel     (sel),
    .sel_vld (sel_vld),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: mode 0 = idle, 1 = granted, 2 = in dead-time gap
  int m_mode = 0;
  int m_sel  = 0;
  int m_last = 7;
  int m_gap  = 0;
  int m_hold = 0;
  bit m_to   = 1'b0;
  bit chk_en = 1'b0;

  bit rec      = 1'b0;
  bit prev_vld = 1'b0;
  int order[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t obs=%0h exp=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int lst);
    for (int k = 1; k <= 8; k++) begin
      if (r[(lst + k) % 8]) return (lst + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [7:0] r, input logic rs);
    int w;
    if (rs) begin
      m_mode = 0; m_sel = 0; m_last = 7; m_gap = 0; m_hold = 0; m_to = 1'b0;
      return;
    end
    m_to = 1'b0;
    if (m_mode == 1) begin
      if (!r[m_sel] || (TO_EN && (m_hold + 1 == int'(HOLD)))) begin
        m_to   = r[m_sel];
        m_mode = 2;
        m_gap  = int'(GAP);
        m_last = m_sel;
      end else begin
        m_hold++;
      end
    end else if (m_mode == 0 || m_gap == 1) begin
      w = pick(r, m_last);
      if (w >= 0) begin
        m_mode = 1; m_sel = w; m_hold = 0;
      end else begin
        m_mode = 0;
      end
    end else begin
      m_gap--;
    end
  endtask

  task automatic check_outputs();
    logic [7:0] e_gnt;
    e_gnt = (m_mode == 1) ? (8'h01 << m_sel) : 8'h00;
    chk("sel",     32'(sel),     32'(m_sel));
    chk("sel_vld", 32'(sel_vld), 32'(m_mode == 1));
    chk("gnt",     32'(gnt),     32'(e_gnt));
    chk("busy",    32'(busy),    32'(m_mode != 0));
    chk("timeout", 32'(timeout), 32'(m_to));
  endtask

  // One clock: check what the last edge produced, then apply inputs for the next.
  task automatic cycle(input logic [7:0] r, input logic rs);
    @(negedge clk);
    if (chk_en) check_outputs();
    if (rec && sel_vld && !prev_vld) order.push_back(int'(sel));
    prev_vld = sel_vld;
    req = r;
    rst = rs;
    model_step(r, rs);
  endtask

  logic [7:0] cur;
  logic [7:0] r;

  initial begin
    // Reset and quiet idle
    cycle(8'h00, 1'b1);
    chk_en = 1'b1;
    cycle(8'h00, 1'b1);
    for (int i = 0; i < 10; i++) cycle(8'h00, 1'b0);

    // Single requester, release, gap, back to idle
    for (int i = 0; i < 3; i++) cycle(8'h01, 1'b0);
    for (int i = 0; i < 5; i++) cycle(8'h00, 1'b0);

    // All requesting, each grantee drops for one cycle after 3 grant cycles
    cycle(8'h00, 1'b1);
    rec = 1'b1;
    for (int i = 0; i < 55; i++) begin
      r = 8'hFF;
      if (m_mode == 1 && m_hold == 2) r[m_sel] = 1'b0;
      cycle(r, 1'b0);
    end
    rec = 1'b0;
    chk("order_len", 32'(order.size() >= 9), 32'd1);
    for (int i = 0; i < order.size() && i < 9; i++)
      chk("order", 32'(order[i]), 32'(i % 8));

    // Wrap-around priority after channel 5 was last served
    cycle(8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cycle(8'h20, 1'b0);
    cycle(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) cycle(8'h21, 1'b0);
    chk("wrap_sel0", 32'(sel), 32'd0);
    for (int i = 0; i < 8; i++) cycle(8'h20, 1'b0);
    chk("wrap_sel5", 32'(sel), 32'd5);
    for (int i = 0; i < 4; i++) cycle(8'h00, 1'b0);

    // Lone persistent requester (revoked and re-granted when timeout enabled)
    for (int i = 0; i < 20; i++) cycle(8'h08, 1'b0);
    for (int i = 0; i < 4; i++) cycle(8'h00, 1'b0);

    // Reset mid-grant, then priority restarts at channel 0
    for (int i = 0; i < 3; i++) cycle(8'h40, 1'b0);
    cycle(8'h41, 1'b1);
    for (int i = 0; i < 4; i++) cycle(8'h41, 1'b0);
    chk("post_rst_sel", 32'(sel), 32'd0);
    for (int i = 0; i < 4; i++) cycle(8'h00, 1'b0);

    // Randomized requesters with occasional reset
    cur = 8'h00;
    for (int n = 0; n < 4000; n++) begin
      for (int ch = 0; ch < 8; ch++) begin
        if (m_mode == 1 && m_sel == ch && cur[ch]) begin
          if ($urandom_range(3) == 0) cur[ch] = 1'b0;
        end else if (!cur[ch]) begin
          if ($urandom_range(5) == 0) cur[ch] = 1'b1;
        end else if ($urandom_range(19) == 0) begin
          cur[ch] = 1'b0;
        end
      end
      cycle(cur, ($urandom_range(299) == 0));
    end
    cycle(8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
